// File: rtl/window_source_actor_pkg.sv
// Shared encodings for the window source actor: firing modes and FSM states.
package window_source_actor_pkg;

    localparam logic [1:0] MODE_SETUP  = 2'b00;
    localparam logic [1:0] MODE_STREAM = 2'b01;

    typedef enum logic [1:0] {
        T_IDLE,
        T_FIRING_START,
        T_FIRING_WAIT
    } top_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_SETUP_RD,
        F_SETUP_LATCH,
        F_SETUP_WR,
        F_STREAM_RUN,
        F_STREAM_DRAIN,
        F_DONE
    } fire_state_t;

    // A window length is usable only if 1 <= len <= size (unsigned, full width).
    function automatic logic len_is_legal(input logic [31:0] len, input int unsigned size);
        return (len != 32'd0) && (len <= size);
    endfunction

endpackage

// File: rtl/window_source_actor_if.sv
// FIFO-side and scheduler-side signals of the window source actor.
interface window_source_actor_if #(parameter int WIDTH = 10);
    logic [WIDTH-1:0] sample_FIFO;
    logic [WIDTH-1:0] len_cfg_FIFO;
    logic [WIDTH-1:0] cmd_cfg_FIFO;
    logic             invoke;
    logic [1:0]       next_mode_in;
    logic             rd_sample_FIFO;
    logic             rd_len_cfg_FIFO;
    logic             rd_cmd_cfg_FIFO;
    logic             wr_length_FIFO;
    logic             wr_command_FIFO;
    logic             wr_data_FIFO;
    logic [WIDTH-1:0] length_out;
    logic [WIDTH-1:0] command_out;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       next_mode_out;
    logic             FC;
    logic             cfg_err;

    // Actor side.
    modport slave (
        input  sample_FIFO, len_cfg_FIFO, cmd_cfg_FIFO, invoke, next_mode_in,
        output rd_sample_FIFO, rd_len_cfg_FIFO, rd_cmd_cfg_FIFO,
               wr_length_FIFO, wr_command_FIFO, wr_data_FIFO,
               length_out, command_out, data_out, next_mode_out, FC, cfg_err
    );

    // Scheduler / FIFO side.
    modport master (
        output sample_FIFO, len_cfg_FIFO, cmd_cfg_FIFO, invoke, next_mode_in,
        input  rd_sample_FIFO, rd_len_cfg_FIFO, rd_cmd_cfg_FIFO,
               wr_length_FIFO, wr_command_FIFO, wr_data_FIFO,
               length_out, command_out, data_out, next_mode_out, FC, cfg_err
    );
endinterface

// File: rtl/window_source_actor_firing_fsm.sv
// Firing FSM of the window source actor: config pull, window length store,
// sample streaming and firing completion.
//
// state          | meaning
// F_IDLE         | waiting for start from the invoke FSM; mode sampled here
// F_SETUP_RD     | read enable on both config FIFOs
// F_SETUP_LATCH  | config tokens valid on FIFO heads, capture and check L
// F_SETUP_WR     | write length/command tokens (legal L only), store L
// F_STREAM_RUN   | read enable on sample FIFO, L consecutive cycles
// F_STREAM_DRAIN | final data write (also the pad cycle when stored L is 0)
// F_DONE         | FC pulse with next_mode / cfg_err
//
// Unknown modes (10/11) go straight to F_DONE: FC two cycles after invoke.
module window_source_firing_FSM
    import window_source_actor_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] len_cfg_i,
    input  logic [WIDTH-1:0] cmd_cfg_i,
    output logic             rd_sample_o,
    output logic             rd_len_cfg_o,
    output logic             rd_cmd_cfg_o,
    output logic             wr_length_o,
    output logic             wr_command_o,
    output logic             wr_data_o,
    output logic [WIDTH-1:0] length_o,
    output logic [WIDTH-1:0] command_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       next_mode_o,
    output logic             fc_o,
    output logic             cfg_err_o
);

    fire_state_t      state_q;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] cmd_q;
    logic [WIDTH-1:0] l_q;
    logic [WIDTH-1:0] cnt_q;
    logic             legal_q;
    logic             err_q;
    logic             wr_data_q;
    logic [1:0]       nm_q;

    // Firing sequencer, window length register, sample counter and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= F_IDLE;
            len_q     <= '0;
            cmd_q     <= '0;
            l_q       <= '0;
            cnt_q     <= '0;
            legal_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_data_q <= 1'b0;
            nm_q      <= MODE_SETUP;
        end else begin
            // Data writes trail sample reads by exactly one cycle.
            wr_data_q <= (state_q == F_STREAM_RUN);
            case (state_q)
                F_IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        nm_q  <= MODE_SETUP;
                        cnt_q <= '0;
                        if (mode_i == MODE_SETUP) begin
                            state_q <= F_SETUP_RD;
                        end else if (mode_i == MODE_STREAM) begin
                            if (l_q == '0) begin
                                err_q   <= 1'b1;
                                state_q <= F_STREAM_DRAIN;
                            end else begin
                                state_q <= F_STREAM_RUN;
                            end
                        end else begin
                            state_q <= F_DONE;
                        end
                    end
                end
                F_SETUP_RD:    state_q <= F_SETUP_LATCH;
                F_SETUP_LATCH: begin
                    len_q   <= len_cfg_i;
                    cmd_q   <= cmd_cfg_i;
                    legal_q <= len_is_legal(32'(len_cfg_i), SIZE);
                    state_q <= F_SETUP_WR;
                end
                F_SETUP_WR: begin
                    if (legal_q) begin
                        l_q  <= len_q;
                        nm_q <= MODE_STREAM;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= F_DONE;
                end
                F_STREAM_RUN: begin
                    if (cnt_q == l_q - WIDTH'(1)) begin
                        state_q <= F_STREAM_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                F_STREAM_DRAIN: state_q <= F_DONE;
                F_DONE:         state_q <= F_IDLE;
                default:        state_q <= F_IDLE;
            endcase
        end
    end

    assign rd_len_cfg_o = (state_q == F_SETUP_RD);
    assign rd_cmd_cfg_o = (state_q == F_SETUP_RD);
    assign wr_length_o  = (state_q == F_SETUP_WR) && legal_q;
    assign wr_command_o = (state_q == F_SETUP_WR) && legal_q;
    assign rd_sample_o  = (state_q == F_STREAM_RUN);
    assign wr_data_o    = wr_data_q;
    assign length_o     = len_q;
    assign command_o    = cmd_q;
    assign data_o       = wr_data_q ? sample_i : '0;
    assign next_mode_o  = nm_q;
    assign fc_o         = (state_q == F_DONE);
    assign cfg_err_o    = (state_q == F_DONE) && err_q;

endmodule

// File: rtl/window_source_actor.sv
// Window source actor top: invoke FSM wrapping one firing FSM.
//
// state          | meaning
// T_IDLE         | waiting for invoke
// T_FIRING_START | start pulse to the firing FSM, next_mode_in taken by it
// T_FIRING_WAIT  | firing in progress; invoke ignored until FC
module window_source_actor
    import window_source_actor_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    window_source_actor_if.slave io
);

    top_state_t state_q;
    logic       start_child;
    logic       child_done;

    // Invoke handshake: accept invoke only when idle, release on child completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
        end else begin
            case (state_q)
                T_IDLE:         if (io.invoke) state_q <= T_FIRING_START;
                T_FIRING_START: state_q <= T_FIRING_WAIT;
                T_FIRING_WAIT:  if (child_done) state_q <= T_IDLE;
                default:        state_q <= T_IDLE;
            endcase
        end
    end

    assign start_child = (state_q == T_FIRING_START);
    assign io.FC       = child_done;

    window_source_firing_FSM #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_firing (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_child),
        .mode_i       (io.next_mode_in),
        .sample_i     (io.sample_FIFO),
        .len_cfg_i    (io.len_cfg_FIFO),
        .cmd_cfg_i    (io.cmd_cfg_FIFO),
        .rd_sample_o  (io.rd_sample_FIFO),
        .rd_len_cfg_o (io.rd_len_cfg_FIFO),
        .rd_cmd_cfg_o (io.rd_cmd_cfg_FIFO),
        .wr_length_o  (io.wr_length_FIFO),
        .wr_command_o (io.wr_command_FIFO),
        .wr_data_o    (io.wr_data_FIFO),
        .length_o     (io.length_out),
        .command_o    (io.command_out),
        .data_o       (io.data_out),
        .next_mode_o  (io.next_mode_out),
        .fc_o         (child_done),
        .cfg_err_o    (io.cfg_err)
    );

endmodule
